// File: rtl/inst_fifo.sv
// ---------------------------------------------------------------------------
// inst_fifo -- dual-issue instruction FIFO between fetch and decode.
//
// Stores {pc, instruction} pairs in a circular buffer. Fetch may push up to
// two entries per cycle and decode may pop up to two entries per cycle. The
// head and head+1 entries are presented combinationally so that a dual-issue
// decoder can consume them directly.
//
// Optional feature (macro INST_FIFO_ISSUE_CNT_EN): adds a 32-bit issue_cnt
// output that accumulates the number of entries actually popped. Without the
// macro the port and its logic are absent.
//
// Ports
//   clk                    single clock, rising edge
//   rst                    asynchronous, active-high reset of control state
//   flush                  discard every entry
//   flush_keep_ds          pop this cycle, then keep only the oldest entry
//   delay_slot_flush       discard every entry including the delay slot
//   write_en1/2            push slot 1 / slot 2 (slot 2 needs slot 1)
//   write_data1/2          instruction words to push
//   write_addr1/2          PCs of the pushed instructions
//   read_en1/2             master / slave pop (slave needs master)
//   read_data1/2           instruction words at head / head+1 (0 if absent)
//   read_addr1/2           PCs at head / head+1 (0 if absent)
//   empty                  count == 0
//   almost_empty           count < 2
//   full                   count >= DEPTH-1; pushes are dropped while high
//   issue_cnt (optional)   running total of popped entries, wraps at 2^32
// ---------------------------------------------------------------------------
module inst_fifo #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        flush_keep_ds,
   input  logic        delay_slot_flush,
   input  logic        write_en1,
   input  logic        write_en2,
   input  logic [31:0] write_data1,
   input  logic [31:0] write_data2,
   input  logic [31:0] write_addr1,
   input  logic [31:0] write_addr2,
   input  logic        read_en1,
   input  logic        read_en2,
   output logic [31:0] read_data1,
   output logic [31:0] read_data2,
   output logic [31:0] read_addr1,
   output logic [31:0] read_addr2,
   output logic        empty,
   output logic        almost_empty,
   output logic        full
`ifdef INST_FIFO_ISSUE_CNT_EN
   ,
   output logic [31:0] issue_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Storage is deliberately not reset; stale words are masked by count.
   logic [63:0]   mem [DEPTH];

   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [CW-1:0] count_q, count_d;

   logic          push1, push2, pop1, pop2;
   logic          we1, we2;
   logic [CW-1:0] push_cnt, pop_cnt, remain;
   logic [AW-1:0] rptr_pop, rptr_p1, wptr_p1;

   assign rptr_p1 = rptr_q + AW'(1);
   assign wptr_p1 = wptr_q + AW'(1);

   assign empty        = (count_q == '0);
   assign almost_empty = (count_q < CW'(2));
   assign full         = (count_q >= CW'(DEPTH - 1));

   assign read_data1 = empty        ? '0 : mem[rptr_q][31:0];
   assign read_addr1 = empty        ? '0 : mem[rptr_q][63:32];
   assign read_data2 = almost_empty ? '0 : mem[rptr_p1][31:0];
   assign read_addr2 = almost_empty ? '0 : mem[rptr_p1][63:32];

   always_comb begin
      // Slot 2 only counts alongside slot 1; pops are clamped to what exists.
      push1    = write_en1 & ~full;
      push2    = push1 & write_en2;
      pop1     = read_en1 & ~empty;
      pop2     = pop1 & read_en2 & ~almost_empty;
      push_cnt = CW'(push1) + CW'(push2);
      pop_cnt  = CW'(pop1) + CW'(pop2);
      remain   = count_q - pop_cnt;
      rptr_pop = rptr_q + AW'(pop_cnt);

      rptr_d  = rptr_pop;
      wptr_d  = wptr_q;
      count_d = count_q;
      we1     = 1'b0;
      we2     = 1'b0;

      if (delay_slot_flush || flush) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else if (flush_keep_ds) begin
         // Pops happen first; whatever is then oldest is the delay slot.
         if (remain != '0) begin
            wptr_d  = rptr_pop + AW'(1);
            count_d = CW'(1);
         end else if (write_en1) begin
            // Nothing left in the buffer: the delay slot is arriving now.
            we1     = 1'b1;
            rptr_d  = wptr_q;
            wptr_d  = wptr_p1;
            count_d = CW'(1);
         end else begin
            count_d = '0;
         end
      end else begin
         we1     = push1;
         we2     = push2;
         wptr_d  = wptr_q + AW'(push_cnt);
         count_d = count_q + push_cnt - pop_cnt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Writes are suppressed while rst is high so a reset edge leaves no trace.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (we1) mem[wptr_q]  <= {write_addr1, write_data1};
         if (we2) mem[wptr_p1] <= {write_addr2, write_data2};
      end
   end

`ifdef INST_FIFO_ISSUE_CNT_EN
   logic [31:0] issue_cnt_q, issue_cnt_d;

   // Counts every entry handed to decode, regardless of any flush.
   always_comb begin
      issue_cnt_d = issue_cnt_q + 32'(pop_cnt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) issue_cnt_q <= '0;
      else     issue_cnt_q <= issue_cnt_d;
   end

   assign issue_cnt = issue_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fifo.sv
module tb_inst_fifo;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0, flush_keep_ds = 1'b0, delay_slot_flush = 1'b0;
   logic        write_en1 = 1'b0, write_en2 = 1'b0;
   logic [31:0] write_data1 = '0, write_data2 = '0;
   logic [31:0] write_addr1 = '0, write_addr2 = '0;
   logic        read_en1 = 1'b0, read_en2 = 1'b0;
   logic [31:0] read_data1, read_data2, read_addr1, read_addr2;
   logic        empty, almost_empty, full;
`ifdef INST_FIFO_ISSUE_CNT_EN
   logic [31:0] issue_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: an ordered list of {pc, word}, oldest first.
   logic [63:0] mq[$];
   logic [31:0] issue_m = '0;

   inst_fifo #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .flush_keep_ds(flush_keep_ds),
      .delay_slot_flush(delay_slot_flush),
      .write_en1(write_en1), .write_en2(write_en2),
      .write_data1(write_data1), .write_data2(write_data2),
      .write_addr1(write_addr1), .write_addr2(write_addr2),
      .read_en1(read_en1), .read_en2(read_en2),
      .read_data1(read_data1), .read_data2(read_data2),
      .read_addr1(read_addr1), .read_addr2(read_addr2),
      .empty(empty), .almost_empty(almost_empty), .full(full)
`ifdef INST_FIFO_ISSUE_CNT_EN
      , .issue_cnt(issue_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ea(int k);
      return 32'hBFC0_0000 + 32'(k * 4);
   endfunction

   function automatic logic [31:0] ed(int k);
      return 32'h1000_0000 + 32'(k);
   endfunction

   task automatic idle();
      flush = 0; flush_keep_ds = 0; delay_slot_flush = 0;
      write_en1 = 0; write_en2 = 0; read_en1 = 0; read_en2 = 0;
   endtask

   task automatic push1(int k);
      write_en1 = 1; write_en2 = 0;
      write_addr1 = ea(k); write_data1 = ed(k);
   endtask

   task automatic push2(int k);
      write_en1 = 1; write_en2 = 1;
      write_addr1 = ea(k);     write_data1 = ed(k);
      write_addr2 = ea(k + 1); write_data2 = ed(k + 1);
   endtask

   // Applies the FIFO rules to the list using the inputs seen at this edge.
   task automatic model_clk();
      int n, pops;
      logic [63:0] keep;
      n = mq.size();
      pops = 0;
      if (read_en1) pops = (read_en2 && n >= 2) ? 2 : ((n >= 1) ? 1 : 0);
      issue_m = issue_m + 32'(pops);
      if (delay_slot_flush || flush) begin
         mq.delete();
      end else if (flush_keep_ds) begin
         repeat (pops) void'(mq.pop_front());
         if (mq.size() > 0) begin
            keep = mq[0];
            mq.delete();
            mq.push_back(keep);
         end else if (write_en1) begin
            mq.push_back({write_addr1, write_data1});
         end
      end else begin
         repeat (pops) void'(mq.pop_front());
         if (write_en1 && n < DEPTH - 1) begin
            mq.push_back({write_addr1, write_data1});
            if (write_en2) mq.push_back({write_addr2, write_data2});
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_clk();
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      mq.delete();
      issue_m = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
      n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
      n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
      n_checks++; if ({read_data1, read_addr1, read_data2, read_addr2} !== 128'd0) begin
         n_fail++; $display("FAIL reset_read_outputs: got %h %h %h %h want all 0", read_data1, read_addr1, read_data2, read_addr2);
      end
`ifdef INST_FIFO_ISSUE_CNT_EN
      n_checks++; if (issue_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_issue_cnt: got %0d want 0", issue_cnt); end
`endif
      // Asynchronous assertion mid-cycle, then a push held during reset.
      push1(3);
      step();
      idle();
      #2;
      rst = 1;
      #1;
      n_checks++; if (empty !== 1'b1 || read_data1 !== 32'd0) begin
         n_fail++; $display("FAIL async_reset: got empty=%b data=%h want empty=1 data=0", empty, read_data1);
      end
      mq.delete();
      issue_m = '0;
      push2(5);
      @(posedge clk);
      #1;
      idle();
      rst = 0;
      step();
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL push_during_reset: got empty=%b want 1", empty); end
   endtask

   task automatic test_first_push();
      do_reset();
      write_en1 = 1; write_en2 = 1;
      write_addr1 = 32'hBFC0_0000; write_data1 = 32'h2408_0001;
      write_addr2 = 32'hBFC0_0004; write_data2 = 32'h2409_0002;
      step();
      idle();
      n_checks++; if (read_addr1 !== 32'hBFC0_0000) begin n_fail++; $display("FAIL first_addr1: got %h want bfc00000", read_addr1); end
      n_checks++; if (read_addr2 !== 32'hBFC0_0004) begin n_fail++; $display("FAIL first_addr2: got %h want bfc00004", read_addr2); end
      n_checks++; if (read_data1 !== 32'h2408_0001 || read_data2 !== 32'h2409_0002) begin
         n_fail++; $display("FAIL first_data: got %h %h want 24080001 24090002", read_data1, read_data2);
      end
      n_checks++; if (almost_empty !== 1'b0 || empty !== 1'b0 || full !== 1'b0) begin
         n_fail++; $display("FAIL first_flags: got ae=%b e=%b f=%b want 0 0 0", almost_empty, empty, full);
      end
   endtask

   task automatic test_fill_full();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         push2(2 * k);
         step();
         if (k == 6) begin
            n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_at_14: got %b want 0", full); end
         end
      end
      n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_at_16: got %b want 1", full); end
      push2(100);
      step();
      idle();
      n_checks++; if (full !== 1'b1 || read_data1 !== ed(0)) begin
         n_fail++; $display("FAIL dropped_push: got full=%b head=%h want 1 %h", full, read_data1, ed(0));
      end
      read_en1 = 1;
      step();
      n_checks++; if (full !== 1'b1 || read_data1 !== ed(1)) begin
         n_fail++; $display("FAIL full_at_15: got full=%b head=%h want 1 %h", full, read_data1, ed(1));
      end
      read_en2 = 1;
      for (int j = 0; j < 7; j++) begin
         step();
         n_checks++; if (read_data1 !== ed(3 + 2 * j) || read_addr1 !== ea(3 + 2 * j)) begin
            n_fail++; $display("FAIL drain_head%0d: got %h want %h", j, read_data1, ed(3 + 2 * j));
         end
      end
      n_checks++; if (almost_empty !== 1'b1 || empty !== 1'b0 || full !== 1'b0) begin
         n_fail++; $display("FAIL drain_last: got ae=%b e=%b f=%b want 1 0 0", almost_empty, empty, full);
      end
      read_en2 = 0;
      step();
      idle();
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
   endtask

   task automatic test_pop_clamp();
      do_reset();
      push1(40);
      step();
      idle();
      read_en1 = 1; read_en2 = 1;
      push1(41);
      step();
      idle();
      n_checks++; if (empty !== 1'b0 || almost_empty !== 1'b1) begin
         n_fail++; $display("FAIL clamp_count: got e=%b ae=%b want 0 1", empty, almost_empty);
      end
      n_checks++; if (read_data1 !== ed(41) || read_addr1 !== ea(41) || read_data2 !== 32'd0) begin
         n_fail++; $display("FAIL clamp_head: got %h %h %h want %h %h 0", read_data1, read_addr1, read_data2, ed(41), ea(41));
      end
   endtask

   task automatic test_keep_ds_pop();
      do_reset();
      push2(0); step();
      push2(2); step();
      push1(4); step();
      idle();
      read_en1 = 1; flush_keep_ds = 1;
      push2(50);
      step();
      idle();
      n_checks++; if (empty !== 1'b0 || almost_empty !== 1'b1) begin
         n_fail++; $display("FAIL keep_count: got e=%b ae=%b want 0 1", empty, almost_empty);
      end
      n_checks++; if (read_data1 !== ed(1) || read_addr1 !== ea(1)) begin
         n_fail++; $display("FAIL keep_head: got %h %h want %h %h", read_data1, read_addr1, ed(1), ea(1));
      end
      push2(60);
      step();
      idle();
      n_checks++; if (read_data1 !== ed(1) || read_data2 !== ed(60) || almost_empty !== 1'b0) begin
         n_fail++; $display("FAIL keep_then_push: got %h %h ae=%b want %h %h 0", read_data1, read_data2, almost_empty, ed(1), ed(60));
      end
   endtask

   task automatic test_flush_priority();
      do_reset();
      push2(0); step();
      push2(2); step();
      push1(4); step();
      idle();
      flush_keep_ds = 1; delay_slot_flush = 1;
      push2(70);
      step();
      idle();
      n_checks++; if (empty !== 1'b1 || read_data1 !== 32'd0) begin
         n_fail++; $display("FAIL dsflush_wins: got e=%b head=%h want 1 0", empty, read_data1);
      end
      flush_keep_ds = 1;
      push2(80);
      step();
      idle();
      n_checks++; if (empty !== 1'b0 || almost_empty !== 1'b1 || read_data1 !== ed(80) || read_addr1 !== ea(80)) begin
         n_fail++; $display("FAIL keep_from_empty: got e=%b ae=%b head=%h want 0 1 %h", empty, almost_empty, read_data1, ed(80));
      end
      flush = 1; flush_keep_ds = 1;
      push2(90);
      step();
      idle();
      n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL flush_wins: got e=%b want 1", empty); end
   endtask

   task automatic test_random();
      logic [31:0] x_d1, x_a1, x_d2, x_a2;
      int r, sz;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         idle();
         if (((i / 100) % 2) == 0) begin
            write_en1 = ($urandom_range(0, 3) != 0);
            read_en1  = ($urandom_range(0, 3) == 0);
         end else begin
            write_en1 = ($urandom_range(0, 3) == 0);
            read_en1  = ($urandom_range(0, 3) != 0);
         end
         write_en2   = $urandom_range(0, 1);
         read_en2    = $urandom_range(0, 1);
         write_data1 = $urandom(); write_addr1 = $urandom();
         write_data2 = $urandom(); write_addr2 = $urandom();
         r = $urandom_range(0, 63);
         delay_slot_flush = (r == 0);
         flush            = (r == 1);
         flush_keep_ds    = (r >= 2 && r <= 5) || (r == 0);
         step();
         sz   = mq.size();
         x_d1 = (sz >= 1) ? mq[0][31:0]  : 32'd0;
         x_a1 = (sz >= 1) ? mq[0][63:32] : 32'd0;
         x_d2 = (sz >= 2) ? mq[1][31:0]  : 32'd0;
         x_a2 = (sz >= 2) ? mq[1][63:32] : 32'd0;
         n_checks++; if (empty !== (sz == 0)) begin n_fail++; $display("FAIL rnd_empty@%0d: got %b size %0d", i, empty, sz); end
         n_checks++; if (almost_empty !== (sz < 2)) begin n_fail++; $display("FAIL rnd_almost_empty@%0d: got %b size %0d", i, almost_empty, sz); end
         n_checks++; if (full !== (sz >= DEPTH - 1)) begin n_fail++; $display("FAIL rnd_full@%0d: got %b size %0d", i, full, sz); end
         n_checks++; if (read_data1 !== x_d1 || read_addr1 !== x_a1) begin
            n_fail++; $display("FAIL rnd_head@%0d: got %h:%h want %h:%h", i, read_addr1, read_data1, x_a1, x_d1);
         end
         n_checks++; if (read_data2 !== x_d2 || read_addr2 !== x_a2) begin
            n_fail++; $display("FAIL rnd_next@%0d: got %h:%h want %h:%h", i, read_addr2, read_data2, x_a2, x_d2);
         end
`ifdef INST_FIFO_ISSUE_CNT_EN
         n_checks++; if (issue_cnt !== issue_m) begin n_fail++; $display("FAIL rnd_issue_cnt@%0d: got %0d want %0d", i, issue_cnt, issue_m); end
`endif
      end
      idle();
   endtask

`ifdef INST_FIFO_ISSUE_CNT_EN
   task automatic test_issue_cnt();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         push2(2 * k);
         step();
      end
      idle();
      read_en1 = 1; read_en2 = 1;
      repeat (3) step();
      read_en2 = 0;
      step();
      idle();
      n_checks++; if (issue_cnt !== 32'd7) begin n_fail++; $display("FAIL issue_cnt_7: got %0d want 7", issue_cnt); end
      n_checks++; if (read_data1 !== ed(7) || almost_empty !== 1'b1) begin
         n_fail++; $display("FAIL issue_cnt_head: got %h ae=%b want %h 1", read_data1, almost_empty, ed(7));
      end
      #2;
      rst = 1;
      #1;
      n_checks++; if (issue_cnt !== 32'd0) begin n_fail++; $display("FAIL issue_cnt_reset: got %0d want 0", issue_cnt); end
      do_reset();
   endtask
`endif

   initial begin
      test_reset();
      test_first_push();
      test_fill_full();
      test_pop_clamp();
      test_keep_ds_pop();
      test_flush_priority();
      test_random();
`ifdef INST_FIFO_ISSUE_CNT_EN
      test_issue_cnt();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
